// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester handshakes, shared response and ALU drive/return lines.
// slave = arbiter side, master = requesters plus the shared ALU.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_sel;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             rsp0_valid;
  logic             rsp0_ready;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_sel;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp1_valid;
  logic             rsp1_ready;

  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  req0_valid, req0_sel, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_sel, req1_a, req1_b, rsp1_ready,
    input  alu_result,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    output rsp_result, rsp_zero, alu_sel, alu_a, alu_b
  );

  modport master (
    output req0_valid, req0_sel, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_sel, req1_a, req1_b, rsp1_ready,
    output alu_result,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    input  rsp_result, rsp_zero, alu_sel, alu_a, alu_b
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for one shared combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_RR_EN for round-robin contention; default is fixed priority (req0 wins).
module alu_share_arbiter #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] IDLE_SEL = 4'b0010
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);

`ifdef ALU_ARB_RR_EN
  localparam logic RR_MODE = 1'b1;
`else
  localparam logic RR_MODE = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic             owner_r;
  logic             last_grant_r;
  logic [3:0]       op_sel_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic             rsp_zero_r;
  logic             rsp0_valid_r;
  logic             rsp1_valid_r;
  logic [3:0]       alu_sel_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;

  logic             grant_valid_s;
  logic             grant_s;
  logic [3:0]       win_sel_s;
  logic [WIDTH-1:0] win_a_s;
  logic [WIDTH-1:0] win_b_s;
  logic             owner_ack_s;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  // Arbitration: in fixed mode RR_MODE masks last_grant so req0 always wins contention.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    if (state_r == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid_s = 1'b1;
        grant_s       = RR_MODE & ~last_grant_r;
      end else if (bus.req0_valid) begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b0;
      end else if (bus.req1_valid) begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
    end
  end

  // Winner payload mux and owner-side response acknowledge.
  always_comb begin
    win_sel_s   = bus.req0_sel;
    win_a_s     = bus.req0_a;
    win_b_s     = bus.req0_b;
    owner_ack_s = bus.rsp0_ready;
    if (grant_s) begin
      win_sel_s = bus.req1_sel;
      win_a_s   = bus.req1_a;
      win_b_s   = bus.req1_b;
    end else begin
      win_sel_s = bus.req0_sel;
      win_a_s   = bus.req0_a;
      win_b_s   = bus.req0_b;
    end
    if (owner_r) begin
      owner_ack_s = bus.rsp1_ready;
    end else begin
      owner_ack_s = bus.rsp0_ready;
    end
  end

  // Main FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      op_sel_r     <= 4'b0000;
      op_a_r       <= {WIDTH{1'b0}};
      op_b_r       <= {WIDTH{1'b0}};
      rsp_result_r <= {WIDTH{1'b0}};
      rsp_zero_r   <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      alu_sel_r    <= IDLE_SEL;
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            op_sel_r     <= win_sel_s;
            op_a_r       <= win_a_s;
            op_b_r       <= win_b_s;
            alu_sel_r    <= win_sel_s;
            alu_a_r      <= win_a_s;
            alu_b_r      <= win_b_s;
            state_r      <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          rsp_result_r <= bus.alu_result;
          rsp_zero_r   <= is_zero(bus.alu_result);
          rsp0_valid_r <= ~owner_r;
          rsp1_valid_r <= owner_r;
          alu_sel_r    <= IDLE_SEL;
          alu_a_r      <= {WIDTH{1'b0}};
          alu_b_r      <= {WIDTH{1'b0}};
          state_r      <= RESP;
        end
        RESP: begin
          if (owner_ack_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
          alu_sel_r    <= IDLE_SEL;
          alu_a_r      <= {WIDTH{1'b0}};
          alu_b_r      <= {WIDTH{1'b0}};
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = grant_valid_s & ~grant_s;
  assign bus.req1_ready = grant_valid_s & grant_s;
  assign bus.rsp0_valid = rsp0_valid_r;
  assign bus.rsp1_valid = rsp1_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_zero   = rsp_zero_r;
  assign bus.alu_sel    = alu_sel_r;
  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the shared port.
// Expected grant order follows ALU_ARB_RR_EN when the bench is built with it.
module tb_alu_share_arbiter;
  localparam int         WIDTH    = 32;
  localparam logic [3:0] IDLE_SEL = 4'b0010;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .IDLE_SEL(IDLE_SEL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared combinational ALU (ALUsel encoding).
  logic [WIDTH-1:0] alu_res;
  always_comb begin
    alu_res = {WIDTH{1'b0}};
    case (bus.alu_sel)
      4'b0000: alu_res = bus.alu_a & bus.alu_b;
      4'b0001: alu_res = bus.alu_a | bus.alu_b;
      4'b0010: alu_res = bus.alu_a + bus.alu_b;
      4'b0110: alu_res = bus.alu_a - bus.alu_b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      4'b1100: alu_res = ~(bus.alu_a | bus.alu_b);
      default: alu_res = {WIDTH{1'b0}};
    endcase
  end
  assign bus.alu_result = alu_res;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    bit exp_g;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_sel = 4'b0000; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_sel = 4'b0000; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

    // 1. Reset state
    tick; tick;
    #1;
    check_eq("rst_req0_ready", bus.req0_ready, 1'b0);
    check_eq("rst_req1_ready", bus.req1_ready, 1'b0);
    check_eq("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    check_eq("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
    check_eq("rst_alu_sel", bus.alu_sel, IDLE_SEL);
    check_eq("rst_alu_a", bus.alu_a, 32'd0);
    check_eq("rst_alu_b", bus.alu_b, 32'd0);
    check_eq("rst_result", bus.rsp_result, 32'd0);
    check_eq("rst_zero", bus.rsp_zero, 1'b0);
    rst = 1'b0;
    tick;

    // 2. Single req0 ADD 5+7
    bus.req0_valid = 1'b1; bus.req0_sel = 4'b0010; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
    #1;
    check_eq("t2_req0_ready", bus.req0_ready, 1'b1);
    check_eq("t2_req1_ready", bus.req1_ready, 1'b0);
    tick;
    bus.req0_valid = 1'b0;
    #1;
    check_eq("t2_exec_sel", bus.alu_sel, 4'b0010);
    check_eq("t2_exec_a", bus.alu_a, 32'd5);
    check_eq("t2_exec_b", bus.alu_b, 32'd7);
    check_eq("t2_exec_rsp0", bus.rsp0_valid, 1'b0);
    check_eq("t2_exec_ready", bus.req0_ready, 1'b0);
    tick;
    check_eq("t2_rsp0_valid", bus.rsp0_valid, 1'b1);
    check_eq("t2_rsp1_valid", bus.rsp1_valid, 1'b0);
    check_eq("t2_result", bus.rsp_result, 32'd12);
    check_eq("t2_zero", bus.rsp_zero, 1'b0);
    check_eq("t2_resp_alu_sel", bus.alu_sel, IDLE_SEL);
    bus.rsp0_ready = 1'b1;
    tick;
    bus.rsp0_ready = 1'b0;
    #1;
    check_eq("t2_done_rsp0", bus.rsp0_valid, 1'b0);

    // 3. req1 SUB 9-9, response held; req0 waits
    bus.req1_valid = 1'b1; bus.req1_sel = 4'b0110; bus.req1_a = 32'd9; bus.req1_b = 32'd9;
    #1;
    check_eq("t3_req1_ready", bus.req1_ready, 1'b1);
    tick;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_sel = 4'b0010; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
    #1;
    check_eq("t3_exec_req0_ready", bus.req0_ready, 1'b0);
    tick;
    bus.rsp0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t3_hold_rsp1", bus.rsp1_valid, 1'b1);
      check_eq("t3_hold_rsp0", bus.rsp0_valid, 1'b0);
      check_eq("t3_hold_result", bus.rsp_result, 32'd0);
      check_eq("t3_hold_zero", bus.rsp_zero, 1'b1);
      check_eq("t3_hold_req0_ready", bus.req0_ready, 1'b0);
      tick;
    end
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b1;
    #1;
    check_eq("t3_release_req0_ready", bus.req0_ready, 1'b0);
    tick;
    bus.rsp1_ready = 1'b0;
    #1;
    check_eq("t3_rsp1_dropped", bus.rsp1_valid, 1'b0);
    check_eq("t3_req0_ready_after", bus.req0_ready, 1'b1);
    tick;
    bus.req0_valid = 1'b0;
    tick;
    check_eq("t3_req0_result", bus.rsp_result, 32'd3);
    check_eq("t3_req0_rsp", bus.rsp0_valid, 1'b1);
    bus.rsp0_ready = 1'b1;
    tick;
    bus.rsp0_ready = 1'b0;

    // 4. Contention: both valid, both rsp ready tied high
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_sel = 4'b0010; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_sel = 4'b0001; bus.req1_a = 32'd4; bus.req1_b = 32'd8;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = RR && (k % 2 == 1);
      #1;
      check_eq("t4_grant_req0", bus.req0_ready, !exp_g);
      check_eq("t4_grant_req1", bus.req1_ready, exp_g);
      tick;
      tick;
      check_eq("t4_rsp0_valid", bus.rsp0_valid, !exp_g);
      check_eq("t4_rsp1_valid", bus.rsp1_valid, exp_g);
      check_eq("t4_result", bus.rsp_result, exp_g ? 32'd12 : 32'd2);
      tick;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

    // 5. Reset during EXEC drops the op
    bus.req0_valid = 1'b1; bus.req0_sel = 4'b0000; bus.req0_a = 32'hF; bus.req0_b = 32'h3;
    #1;
    check_eq("t5_req0_ready", bus.req0_ready, 1'b1);
    tick;
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("t5_exec_sel", bus.alu_sel, 4'b0000);
    tick;
    rst = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_sel = 4'b0010; bus.req1_a = 32'd20; bus.req1_b = 32'd22;
    #1;
    check_eq("t5_no_rsp0", bus.rsp0_valid, 1'b0);
    check_eq("t5_alu_sel_idle", bus.alu_sel, IDLE_SEL);
    check_eq("t5_req1_ready", bus.req1_ready, 1'b1);
    tick;
    bus.req1_valid = 1'b0;
    #1;
    check_eq("t5_exec_no_rsp0", bus.rsp0_valid, 1'b0);
    tick;
    check_eq("t5_rsp1_valid", bus.rsp1_valid, 1'b1);
    check_eq("t5_rsp0_valid", bus.rsp0_valid, 1'b0);
    check_eq("t5_result", bus.rsp_result, 32'd42);
    bus.rsp1_ready = 1'b1;
    tick;
    bus.rsp1_ready = 1'b0;

    // 6. Back-to-back req0 with rsp0_ready tied high: one accept per 3 cycles
    bus.req0_valid = 1'b1; bus.req0_sel = 4'b0010; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
    bus.rsp0_ready = 1'b1;
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      check_eq("t6_ready_pattern", bus.req0_ready, (i % 3 == 0));
      if (bus.req0_ready) accepts++;
      tick;
    end
    check_eq("t6_accept_count", accepts, 4);
    bus.req0_valid = 1'b0;
    bus.rsp0_ready = 1'b0;

    // 7. Wrap-around: no extension, result truncated to WIDTH
    bus.req0_valid = 1'b1; bus.req0_sel = 4'b0010; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'd1;
    #1;
    check_eq("t7_ready", bus.req0_ready, 1'b1);
    tick;
    bus.req0_valid = 1'b0;
    tick;
    check_eq("t7_rsp0_valid", bus.rsp0_valid, 1'b1);
    check_eq("t7_result", bus.rsp_result, 32'd0);
    check_eq("t7_zero", bus.rsp_zero, 1'b1);
    bus.rsp0_ready = 1'b1;
    tick;
    bus.rsp0_ready = 1'b0;
    #1;
    check_eq("t7_done", bus.rsp0_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
